// File: rtl/fetch_unit.sv
// Instruction fetch stage: reads the PC, fetches one or two 16-bit words over a
// req/ack memory port and hands the assembled instruction to decode over valid/ready.
module fetch_unit #(
  parameter int ADDR_W  = 20,
  parameter int IMM_BIT = 0
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [31:0]       i_pc,
  input  logic              i_flush,
  output logic              o_pc_enable,
  output logic [31:0]       o_pc_next,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_ack,
  input  logic [15:0]       i_mem_data,
  output logic              o_instr_valid,
  input  logic              i_decode_ready,
  output logic [31:0]       o_instr,
  output logic [31:0]       o_instr_pc
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] FETCH_LO = 3'd1;
  localparam logic [2:0] FETCH_HI = 3'd2;
  localparam logic [2:0] HOLD     = 3'd3;
  localparam logic [2:0] DRAIN    = 3'd4;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [2:0]        state_r;
  logic [2:0]        state_nxt_s;
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W-1:0] addr_nxt_s;
  logic [15:0]       op_r;
  logic [15:0]       op_nxt_s;
  logic [15:0]       imm_r;
  logic [15:0]       imm_nxt_s;
  logic [31:0]       pc_r;
  logic [31:0]       pc_nxt_s;
  logic              accept_s;
  logic              has_imm_s;
  logic [31:0]       seq_pc_s;

  // Sequential PC depends on whether the held opcode carries an immediate word.
  assign has_imm_s = op_r[IMM_BIT];
  assign seq_pc_s  = i_pc + (has_imm_s ? 32'd2 : 32'd1);
  assign accept_s  = (state_r == HOLD) && i_decode_ready && !i_flush;

  // Next-state and datapath update; a flush always wins over ack capture and accept.
  always_comb begin
    state_nxt_s = state_r;
    addr_nxt_s  = addr_r;
    op_nxt_s    = op_r;
    imm_nxt_s   = imm_r;
    pc_nxt_s    = pc_r;
    case (state_r)
      IDLE: begin
        if (i_flush) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = FETCH_LO;
          addr_nxt_s  = i_pc[ADDR_W-1:0];
          pc_nxt_s    = i_pc;
        end
      end
      FETCH_LO: begin
        if (i_flush) begin
          state_nxt_s = i_mem_ack ? IDLE : DRAIN;
        end else if (i_mem_ack) begin
          op_nxt_s = i_mem_data;
          if (i_mem_data[IMM_BIT]) begin
            state_nxt_s = FETCH_HI;
            addr_nxt_s  = addr_r + ADDR_ONE;
          end else begin
            state_nxt_s = HOLD;
            imm_nxt_s   = 16'h0000;
          end
        end else begin
          state_nxt_s = FETCH_LO;
        end
      end
      FETCH_HI: begin
        if (i_flush) begin
          state_nxt_s = i_mem_ack ? IDLE : DRAIN;
        end else if (i_mem_ack) begin
          state_nxt_s = HOLD;
          imm_nxt_s   = i_mem_data;
        end else begin
          state_nxt_s = FETCH_HI;
        end
      end
      HOLD: begin
        if (i_flush) begin
          state_nxt_s = IDLE;
        end else if (accept_s) begin
          state_nxt_s = FETCH_LO;
          addr_nxt_s  = seq_pc_s[ADDR_W-1:0];
          pc_nxt_s    = seq_pc_s;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      DRAIN: begin
        // The outstanding read cannot be retracted; its data is simply dropped.
        if (i_mem_ack) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r <= IDLE;
      addr_r  <= {ADDR_W{1'b0}};
      op_r    <= 16'h0000;
      imm_r   <= 16'h0000;
      pc_r    <= 32'h0000_0000;
    end else begin
      state_r <= state_nxt_s;
      addr_r  <= addr_nxt_s;
      op_r    <= op_nxt_s;
      imm_r   <= imm_nxt_s;
      pc_r    <= pc_nxt_s;
    end
  end

  assign o_mem_req     = (state_r == FETCH_LO) || (state_r == FETCH_HI) || (state_r == DRAIN);
  assign o_mem_addr    = addr_r;
  assign o_instr_valid = (state_r == HOLD);
  assign o_instr       = {op_r, imm_r};
  assign o_instr_pc    = pc_r;
  assign o_pc_enable   = accept_s;
  assign o_pc_next     = seq_pc_s;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: random memory latency, decode back-pressure and
// flush redirects, checked against a word-level model of instruction assembly.
module tb_fetch_unit;

  localparam int ADDR_W = 20;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_next;
  } exp_t;

  logic              i_clk = 1'b0;
  logic              i_reset_n;
  logic [31:0]       i_pc;
  logic              i_flush;
  logic              o_pc_enable;
  logic [31:0]       o_pc_next;
  logic              o_mem_req;
  logic [ADDR_W-1:0] o_mem_addr;
  logic              i_mem_ack;
  logic [15:0]       i_mem_data;
  logic              o_instr_valid;
  logic              i_decode_ready;
  logic [31:0]       o_instr;
  logic [31:0]       o_instr_pc;

  fetch_unit #(.ADDR_W(ADDR_W), .IMM_BIT(0)) dut (
    .i_clk          (i_clk),
    .i_reset_n      (i_reset_n),
    .i_pc           (i_pc),
    .i_flush        (i_flush),
    .o_pc_enable    (o_pc_enable),
    .o_pc_next      (o_pc_next),
    .o_mem_req      (o_mem_req),
    .o_mem_addr     (o_mem_addr),
    .i_mem_ack      (i_mem_ack),
    .i_mem_data     (i_mem_data),
    .o_instr_valid  (o_instr_valid),
    .i_decode_ready (i_decode_ready),
    .o_instr        (o_instr),
    .o_instr_pc     (o_instr_pc)
  );

  initial forever #5 i_clk = ~i_clk;

  int tests = 0;
  int fails = 0;
  int acc_count = 0;
  int lat_min, lat_max, ready_pct, flush_pct;
  bit spurious;
  logic [15:0] mem [0:1023];
  exp_t exp_q[$];
  logic [ADDR_W-1:0] ack_addr_q[$];
  logic [31:0] last_instr, last_pc, last_next;
  bit s_acc;
  logic [31:0] s_next;
  logic [31:0] redirect_pc;
  bit busy;
  int cnt;
  bit p_valid, p_acc, p_flush, p_req, p_ack;
  logic [ADDR_W-1:0] p_addr;
  logic [31:0] p_instr, p_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %08h, expected %08h at %0t", name, act, req, $time);
    end
  endtask

  // Instruction at pc: opcode word, plus the next word (address wraps) when bit 0 is set.
  function automatic exp_t model(input logic [31:0] pc);
    logic [ADDR_W-1:0] a0, a1;
    logic [15:0] w0, w1;
    exp_t e;
    a0 = pc[ADDR_W-1:0];
    a1 = a0 + 20'd1;
    w0 = mem[a0[9:0]];
    w1 = w0[0] ? mem[a1[9:0]] : 16'h0000;
    e.instr   = {w0, w1};
    e.pc      = pc;
    e.pc_next = pc + (w0[0] ? 32'd2 : 32'd1);
    return e;
  endfunction

  function automatic logic [31:0] pick_pc();
    case ($urandom_range(0, 4))
      0: return 32'hFFFF_FFFF;
      1: return 32'h000F_FFFF;
      2: return 32'h0000_0020;
      default: return $urandom;
    endcase
  endfunction

  // One cycle of environment: PC register, memory responder, decode and flush source.
  task automatic step();
    @(posedge i_clk);
    #2;
    if (i_flush) begin
      i_pc = redirect_pc;
      exp_q.delete();
      exp_q.push_back(model(i_pc));
    end else if (s_acc) begin
      i_pc = s_next;
      exp_q.push_back(model(i_pc));
    end
    if (i_mem_ack) busy = 1'b0;
    i_mem_ack  = 1'b0;
    i_mem_data = 16'($urandom);
    if (o_mem_req) begin
      if (!busy) begin
        busy = 1'b1;
        cnt  = $urandom_range(lat_max, lat_min);
      end
      if (cnt == 0) begin
        i_mem_ack  = 1'b1;
        i_mem_data = mem[o_mem_addr[9:0]];
      end else begin
        cnt = cnt - 1;
      end
    end else if (spurious && $urandom_range(0, 7) == 0) begin
      i_mem_ack = 1'b1;
    end
    i_decode_ready = ($urandom_range(0, 99) < ready_pct);
    i_flush        = ($urandom_range(0, 99) < flush_pct);
    if (i_flush) redirect_pc = pick_pc();
  endtask

  task automatic do_reset(input logic [31:0] start);
    i_reset_n      = 1'b0;
    i_flush        = 1'b0;
    i_decode_ready = 1'b0;
    i_mem_ack      = 1'b0;
    i_mem_data     = 16'h0000;
    i_pc           = start;
    busy           = 1'b0;
    cnt            = 0;
    exp_q.delete();
    repeat (2) @(posedge i_clk);
    #2;
    chk("rst_req",      {31'd0, o_mem_req}, 32'd0);
    chk("rst_addr",     {12'd0, o_mem_addr}, 32'd0);
    chk("rst_valid",    {31'd0, o_instr_valid}, 32'd0);
    chk("rst_instr",    o_instr, 32'd0);
    chk("rst_instr_pc", o_instr_pc, 32'd0);
    chk("rst_pc_en",    {31'd0, o_pc_enable}, 32'd0);
    i_reset_n = 1'b1;
    exp_q.push_back(model(start));
    ack_addr_q.delete();
  endtask

  task automatic wait_accept(input string name);
    int n0;
    int k;
    n0 = acc_count;
    k  = 0;
    while (acc_count == n0 && k < 50) begin
      step();
      k++;
    end
    tests++;
    if (acc_count == n0) begin
      fails++;
      $display("FAIL %s: no instruction accepted within 50 cycles, expected one", name);
    end
  endtask

  task automatic set_knobs(input int lmin, input int lmax, input int rp, input int fp, input bit sp);
    lat_min = lmin; lat_max = lmax; ready_pct = rp; flush_pct = fp; spurious = sp;
  endtask

  // Monitor: samples mid-cycle, checks handshake rules and pops the scoreboard on accept.
  initial begin : monitor
    bit acc;
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (!i_reset_n) begin
        p_valid = 1'b0; p_acc = 1'b0; p_flush = 1'b0; p_req = 1'b0; p_ack = 1'b0;
        s_acc = 1'b0;
      end else begin
        acc = o_instr_valid && i_decode_ready && !i_flush;
        chk("pc_enable", {31'd0, o_pc_enable}, {31'd0, acc});
        chk("req_while_valid", {31'd0, o_mem_req & o_instr_valid}, 32'd0);
        if (o_mem_req && i_mem_ack) ack_addr_q.push_back(o_mem_addr);
        if (p_acc) begin
          chk("req_after_accept", {31'd0, o_mem_req}, 32'd1);
          chk("valid_after_accept", {31'd0, o_instr_valid}, 32'd0);
        end
        if (p_valid && !p_acc && !p_flush) begin
          chk("stall_valid", {31'd0, o_instr_valid}, 32'd1);
          chk("stall_instr", o_instr, p_instr);
          chk("stall_instr_pc", o_instr_pc, p_pc);
        end
        if (p_req && !p_ack) begin
          chk("req_held", {31'd0, o_mem_req}, 32'd1);
          chk("addr_held", {12'd0, o_mem_addr}, {12'd0, p_addr});
        end
        if (p_flush) chk("valid_after_flush", {31'd0, o_instr_valid}, 32'd0);
        if (p_flush && (p_valid || (p_req && p_ack))) chk("req_after_flush", {31'd0, o_mem_req}, 32'd0);
        if (acc) begin
          acc_count++;
          last_instr = o_instr;
          last_pc    = o_instr_pc;
          last_next  = o_pc_next;
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard: got instr %08h pc %08h, expected no instruction", o_instr, o_instr_pc);
            s_next = o_pc_next;
          end else begin
            e = exp_q.pop_front();
            chk("instr", o_instr, e.instr);
            chk("instr_pc", o_instr_pc, e.pc);
            chk("pc_next", o_pc_next, e.pc_next);
            s_next = e.pc_next;
          end
        end
        s_acc   = acc;
        p_valid = o_instr_valid;
        p_acc   = acc;
        p_flush = i_flush;
        p_req   = o_mem_req;
        p_ack   = i_mem_ack;
        p_addr  = o_mem_addr;
        p_instr = o_instr;
        p_pc    = o_instr_pc;
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

  initial begin : main
    int n0;
    int k;
    for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
    mem[32]   = 16'h1234;
    mem[40]   = 16'h0001;
    mem[41]   = 16'hBEEF;
    mem[1023] = 16'h8001;
    mem[0]    = 16'h5A5A;
    redirect_pc = 32'd0;

    // 16-bit instruction, single-cycle memory latency.
    set_knobs(1, 1, 100, 0, 1'b0);
    do_reset(32'd32);
    wait_accept("t1_wait");
    chk("t1_instr", last_instr, 32'h1234_0000);
    chk("t1_pc", last_pc, 32'd32);
    chk("t1_next", last_next, 32'd33);

    // 32-bit instruction: two reads at 40 and 41.
    do_reset(32'd40);
    wait_accept("t2_wait");
    chk("t2_instr", last_instr, 32'h0001_BEEF);
    chk("t2_next", last_next, 32'd42);
    chk("t2_reads", ack_addr_q.size(), 32'd2);
    if (ack_addr_q.size() >= 2) begin
      chk("t2_addr0", {12'd0, ack_addr_q[0]}, 32'd40);
      chk("t2_addr1", {12'd0, ack_addr_q[1]}, 32'd41);
    end

    // Decode stalls for several cycles, then accepts.
    set_knobs(1, 1, 0, 0, 1'b0);
    do_reset(32'd32);
    repeat (8) step();
    chk("t3_valid", {31'd0, o_instr_valid}, 32'd1);
    chk("t3_no_req", {31'd0, o_mem_req}, 32'd0);
    chk("t3_instr", o_instr, 32'h1234_0000);
    ready_pct = 100;
    wait_accept("t3_wait");
    chk("t3_acc_instr", last_instr, 32'h1234_0000);

    // Address and 32-bit PC wrap.
    set_knobs(0, 2, 100, 0, 1'b0);
    do_reset(32'hFFFF_FFFF);
    wait_accept("t4_wait");
    chk("t4_instr", last_instr, 32'h8001_5A5A);
    chk("t4_pc", last_pc, 32'hFFFF_FFFF);
    chk("t4_next", last_next, 32'h0000_0001);
    if (ack_addr_q.size() >= 2) begin
      chk("t4_addr0", {12'd0, ack_addr_q[0]}, 32'h000F_FFFF);
      chk("t4_addr1", {12'd0, ack_addr_q[1]}, 32'd0);
    end else begin
      chk("t4_reads", ack_addr_q.size(), 32'd2);
    end

    // Random traffic with moderate and heavy flush rates.
    set_knobs(0, 3, 60, 8, 1'b1);
    do_reset(pick_pc());
    n0 = acc_count;
    repeat (3000) step();
    chk("t5_progress", {31'd0, acc_count > n0 + 100}, 32'd1);
    set_knobs(0, 3, 80, 30, 1'b1);
    n0 = acc_count;
    repeat (2000) step();
    chk("t6_progress", {31'd0, acc_count > n0 + 20}, 32'd1);

    // Reset asserted while the immediate word is outstanding.
    set_knobs(2, 2, 100, 0, 1'b0);
    do_reset(32'd40);
    k = 0;
    while (!(o_mem_req && o_mem_addr == 20'd41) && k < 20) begin
      step();
      k++;
    end
    chk("t7_in_fetch_hi", {31'd0, o_mem_req && o_mem_addr == 20'd41}, 32'd1);
    #1;
    i_reset_n = 1'b0;
    #1;
    chk("t7_req_dropped", {31'd0, o_mem_req}, 32'd0);
    chk("t7_valid_low", {31'd0, o_instr_valid}, 32'd0);
    chk("t7_pc_en_low", {31'd0, o_pc_enable}, 32'd0);
    set_knobs(1, 1, 100, 0, 1'b0);
    do_reset(32'd32);
    wait_accept("t7_recover");
    chk("t7_instr", last_instr, 32'h1234_0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
